// File: rtl/bit_packer_pkg.sv
// Shared types and sizing helpers for the bit-stream packer.
package bit_packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Widest word the pad-mask helper can describe; OUT_W must stay below it.
    localparam int MASK_W = 64;

    // Accumulator width: a full word minus one bit can wait while a field lands.
    function automatic int acc_width(input int out_w, input int in_w);
        return out_w + in_w - 1;
    endfunction

    // Bits needed for a count that ranges 0..acc_w.
    function automatic int cnt_width(input int acc_w);
        return $clog2(acc_w + 1);
    endfunction

    // Ones in the positions below out_w-cnt; these are the pad positions of
    // a word that holds only cnt real bits. The caller keeps the low out_w bits.
    function automatic logic [MASK_W-1:0] mask(input int out_w, input int cnt);
        return (MASK_W'(1) << (out_w - cnt)) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/bit_packer.sv
// Handshaked packer: IN_W-bit fields in MSB-first, OUT_W-bit words out.
// The last word of a frame has its unused LSBs filled with PAD_BIT.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int   IN_W    = 5,
    parameter int   OUT_W   = 8,
    parameter logic PAD_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int ACC_W = acc_width(OUT_W, IN_W);
    localparam int CNT_W = cnt_width(ACC_W);

    localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] ALIGN_C = CNT_W'(OUT_W - 1);

    state_t             state, state_d;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic               accept, slot_free, do_extract, do_pad, frame_done;
    logic [OUT_W-1:0]   top_bits, pad_mask, pad_word;
    logic [ACC_W-1:0]   ins;

    // Fields are only taken while less than one word is buffered, so an
    // accept can never collide with an extract and acc never overflows.
    assign in_ready   = rst_n && (state == FILL) && (cnt < OUT_C);
    assign accept     = in_valid && in_ready;
    assign slot_free  = !out_valid || out_ready;
    assign do_extract = slot_free && (cnt >= OUT_C);
    assign do_pad     = slot_free && (state == FLUSH) && (cnt != '0) && (cnt < OUT_C);
    assign frame_done = (do_extract && (cnt == OUT_C)) || do_pad;

    assign top_bits = acc[ACC_W-1 -: OUT_W];
    assign pad_mask = OUT_W'(mask(OUT_W, int'(cnt)));
    assign pad_word = (top_bits & ~pad_mask) | (PAD_BIT ? pad_mask : '0);

    // New field lands directly under the cnt bits already held. The shift is
    // only meaningful while cnt < OUT_W, which is exactly when accept can fire.
    assign ins = ACC_W'(in_data) << (ALIGN_C - cnt);

    // Next-state: a last field starts the flush; the frame's final word ends it.
    always_comb begin
        state_d = state;
        if (state == FILL && accept && in_last)
            state_d = FLUSH;
        else if (state == FLUSH && frame_done)
            state_d = FILL;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_d;
    end

    // Accumulator and bit count: append on accept, drain on extract or pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc | ins;
            cnt <= cnt + IN_C;
        end else if (do_extract) begin
            acc <= acc << OUT_W;
            cnt <= cnt - OUT_C;
        end else if (do_pad) begin
            acc <= '0;
            cnt <= '0;
        end
    end

    // Output slice: loads only when empty or being taken, so a stalled word holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (do_extract) begin
            out_valid <= 1'b1;
            out_data  <= top_bits;
            out_last  <= (state == FLUSH) && (cnt == OUT_C);
        end else if (do_pad) begin
            out_valid <= 1'b1;
            out_data  <= pad_word;
            out_last  <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: default 5->8 instance plus a 4->8 instance.
module tb_bit_packer;

    logic       clk = 1'b0;
    logic       rst_n;

    // default instance (IN_W=5, OUT_W=8)
    logic       d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_out_last;
    logic [4:0] d_in_data;
    logic [7:0] d_out_data;

    // nibble instance (IN_W=4, OUT_W=8)
    logic       n_in_valid, n_in_ready, n_in_last, n_out_valid, n_out_ready, n_out_last;
    logic [3:0] n_in_data;
    logic [7:0] n_out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] fq[$];
    logic [7:0] wq[$];
    logic       lq[$];
    int         fed;

    always #5 clk = ~clk;

    bit_packer u_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_last(d_out_last)
    );

    bit_packer #(.IN_W(4), .OUT_W(8), .PAD_BIT(1'b1)) u_n (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_last(n_in_last),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_last(n_out_last)
    );

    // Feed fq as one frame into u_d and collect words until a last word or budget.
    task automatic run_frame(input bit toggle, input string tag);
        int   cyc = 0;
        bit   done = 0;
        bit   hold = 0;
        bit   acc;
        logic [7:0] held = '0;
        int   n = fq.size();
        fed = 0;
        wq.delete();
        lq.delete();
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (hold) begin
                n_cmp++;
                if (d_out_valid !== 1'b1 || d_out_data !== held) begin
                    n_err++;
                    $display("FAIL %s_stall: got valid=%b data=%h, want valid=1 data=%h",
                             tag, d_out_valid, d_out_data, held);
                end
            end
            d_in_valid  = (fed < n);
            d_in_data   = (fed < n) ? fq[fed] : 5'h0;
            d_in_last   = (fed == n - 1);
            d_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            acc  = d_in_valid && d_in_ready;
            hold = d_out_valid && !d_out_ready;
            held = d_out_data;
            if (d_out_valid && d_out_ready) begin
                wq.push_back(d_out_data);
                lq.push_back(d_out_last);
                if (d_out_last) done = 1;
            end
            @(posedge clk);
            if (acc) fed++;
            cyc++;
        end
        @(negedge clk);
        d_in_valid  = 1'b0;
        d_in_last   = 1'b0;
        d_out_ready = 1'b1;
        n_cmp++;
        if (!done || fed != n) begin
            n_err++;
            $display("FAIL %s_complete: got done=%0d fields=%0d, want done=1 fields=%0d",
                     tag, done, fed, n);
        end
    endtask

    // Compare collected words with expected list; out_last only on the final one.
    task automatic check_words(input logic [7:0] exp[$], input string tag);
        n_cmp++;
        if (wq.size() != exp.size()) begin
            n_err++;
            $display("FAIL %s_count: got %0d words, want %0d", tag, wq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i] !== exp[i] || lq[i] !== (i == exp.size() - 1)) begin
                n_err++;
                $display("FAIL %s_word%0d: got %h last=%b, want %h last=%b",
                         tag, i, wq[i], lq[i], exp[i], (i == exp.size() - 1));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0 || d_out_data !== 8'h00 || d_out_last !== 1'b0 ||
            d_in_ready !== 1'b0 || n_out_valid !== 1'b0 || n_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got d_ov=%b d_od=%h d_ol=%b d_ir=%b n_ov=%b n_ir=%b, want 0/00/0/0/0/0",
                     d_out_valid, d_out_data, d_out_last, d_in_ready, n_out_valid, n_in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got in_ready d=%b n=%b, want 1/1", d_in_ready, n_in_ready);
        end
    endtask

    task automatic test_basic();
        fq = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
        run_frame(1'b0, "basic");
        check_words('{8'h00, 8'h44, 8'h32, 8'h17}, "basic");
    endtask

    task automatic test_pattern();
        fq = '{5'h1F, 5'h0A, 5'h0F, 5'h10, 5'h15, 5'h1B};
        run_frame(1'b0, "pattern");
        check_words('{8'hFA, 8'h9F, 8'h0A, 8'hEF}, "pattern");
    endtask

    task automatic test_backpressure();
        fq = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
        run_frame(1'b1, "bp");
        check_words('{8'h3A, 8'h12, 8'hA5, 8'hB3}, "bp");
    endtask

    task automatic test_single();
        fq = '{5'h15};
        run_frame(1'b0, "single");
        check_words('{8'hAF}, "single");
        // run_frame returns at the negedge after the word was taken
        n_cmp++;
        if (d_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got in_ready=%b, want 1", d_in_ready);
        end
    endtask

    task automatic test_no_pad();
        logic [3:0] f[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [7:0] exp[2] = '{8'hAB, 8'hCD};
        logic [7:0] got[$];
        logic       gl[$];
        int  k = 0;
        int  cyc = 0;
        bit  acc;
        while (cyc < 40) begin
            @(negedge clk);
            n_in_valid  = (k < 4);
            n_in_data   = (k < 4) ? f[k] : 4'h0;
            n_in_last   = (k == 3);
            n_out_ready = 1'b1;
            acc = n_in_valid && n_in_ready;
            if (n_out_valid) begin
                got.push_back(n_out_data);
                gl.push_back(n_out_last);
            end
            @(posedge clk);
            if (acc) k++;
            cyc++;
        end
        @(negedge clk);
        n_in_valid = 1'b0;
        n_in_last  = 1'b0;
        n_cmp++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL nopad_count: got %0d words, want 2", got.size());
        end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp[i] || gl[i] !== (i == 1)) begin
                n_err++;
                $display("FAIL nopad_word%0d: got %h last=%b, want %h last=%b",
                         i, got[i], gl[i], exp[i], (i == 1));
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d_in_valid = 1'b1;
            d_in_data  = 5'h1F;
            d_in_last  = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0 || d_out_data !== 8'h00 || d_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: got valid=%b data=%h in_ready=%b, want 0/00/0",
                     d_out_valid, d_out_data, d_in_ready);
        end
        rst_n       = 1'b1;
        d_out_ready = 1'b1;
        fq = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
        run_frame(1'b0, "postreset");
        check_words('{8'h00, 8'h44, 8'h32, 8'h17}, "postreset");
    endtask

    initial begin
        rst_n       = 1'b0;
        d_in_valid  = 1'b0; d_in_data = '0; d_in_last = 1'b0; d_out_ready = 1'b1;
        n_in_valid  = 1'b0; n_in_data = '0; n_in_last = 1'b0; n_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_pattern();
        test_backpressure();
        test_single();
        test_no_pad();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
